// File: rtl/exconv_rgb30a_pack.sv
// RGB30A packer: four Exp12 lanes (A/R/G/B) to one 32-bit RGB30A word.
// Two-stage valid/ready pipeline with a sticky saturation flag.
module exconv_rgb30a_pack (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_val,
   input  logic [1:0]  in_fmt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_val,
   output logic        sat_sticky,
   input  logic        sat_clear
);

   typedef struct packed {
      logic       zero;
      logic       ovf;
      logic       sgn;
      logic [3:0] e4;
      logic [3:0] man;
   } fp8_t;

   // mw = stored mantissa width (2..4); man is right-aligned
   function automatic fp8_t fp8_lane(
      input logic [11:0] v,
      input logic        uns,
      input logic [2:0]  mw
   );
      logic [4:0] e;
      logic [5:0] m;
      logic [5:0] mt;
      logic       rb;
      logic [6:0] full;
      logic       carry;
      logic [5:0] er;
      logic [3:0] mask;
      fp8_t       r;
      e     = v[10:6];
      m     = v[5:0];
      mt    = m >> (3'd6 - mw);
      rb    = m[3'd5 - mw];
      full  = {1'b0, mt} + {6'd0, rb};
      carry = full[mw];
      er    = {1'b0, e} + {5'd0, carry};
      mask  = 4'hF >> (3'd4 - mw);
      r.sgn  = v[11] & ~uns;
      r.zero = (uns & v[11]) | (e <= 5'd8);
      r.ovf  = ~r.zero & ((e == 5'd31) | (er > 6'd23));
      r.e4   = er[3:0] - 4'd8;
      r.man  = full[3:0] & mask;
      return r;
   endfunction

   // {sat, field}
   function automatic logic [10:0] lin_lane(
      input logic [11:0] v,
      input logic        uns
   );
      logic [10:0] r;
      if (!uns)
         r = {1'b0, v[11:2]};
      else if (v[11])
         r = {1'b1, 10'h3FF};
      else
         r = {1'b0, v[10:1]};
      return r;
   endfunction

   function automatic logic [7:0] fp8_field(
      input fp8_t l,
      input logic uns,
      input logic wide
   );
      logic [3:0] e4;
      logic [3:0] man;
      logic [7:0] r;
      e4  = l.ovf ? 4'hF : l.e4;
      man = l.ovf ? 4'hF : l.man;
      r   = 8'h00;
      if (!l.zero) begin
         unique case ({uns, wide})
            2'b00: r = {1'b0, l.sgn, e4, man[1:0]};
            2'b01: r = {l.sgn, e4, man[2:0]};
            2'b10: r = {1'b0, e4, man[2:0]};
            2'b11: r = {e4, man};
            default: r = 8'h00;
         endcase
      end
      return r;
   endfunction

   logic              s1_valid;
   logic [1:0]        s1_fmt;
   fp8_t [3:0]        s1_fp;
   logic [2:0][10:0]  s1_lin;
   logic              out_sat;

   logic              s1_adv;
   logic              s2_adv;
   fp8_t [3:0]        d_fp;
   logic [2:0][10:0]  d_lin;
   logic [7:0]        f_a;
   logic [6:0]        f_r;
   logic [7:0]        f_g;
   logic [6:0]        f_b;
   logic [31:0]       s2_val;
   logic              s2_sat;

   assign s2_adv   = !out_valid | out_ready;
   assign s1_adv   = !s1_valid | s2_adv;
   assign in_ready = s1_adv;

   // lanes 1 (G) and 3 (A) are stored 8 bits wide, 0 (B) and 2 (R) 7 bits
   always_comb begin
      d_fp = '0;
      for (int i = 0; i < 4; i++) begin
         d_fp[i] = fp8_lane(in_val[16*i+4 +: 12], in_fmt[0],
                            3'd2 + 3'(i % 2) + {2'b0, in_fmt[0]});
      end
   end

   always_comb begin
      d_lin = '0;
      for (int i = 0; i < 3; i++) begin
         d_lin[i] = lin_lane(in_val[16*i+4 +: 12], in_fmt[0]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_fmt   <= '0;
         s1_fp    <= '0;
         s1_lin   <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_fmt <= in_fmt;
            s1_fp  <= d_fp;
            s1_lin <= d_lin;
         end
      end
   end

   always_comb begin
      f_a = fp8_field(s1_fp[3], s1_fmt[0], 1'b1);
      f_r = 7'(fp8_field(s1_fp[2], s1_fmt[0], 1'b0));
      f_g = fp8_field(s1_fp[1], s1_fmt[0], 1'b1);
      f_b = 7'(fp8_field(s1_fp[0], s1_fmt[0], 1'b0));
      if (s1_fmt[1]) begin
         s2_val = {s1_fmt, f_a, f_r, f_g, f_b};
         s2_sat = s1_fp[3].ovf | s1_fp[2].ovf |
                  s1_fp[1].ovf | s1_fp[0].ovf;
      end else begin
         s2_val = {s1_fmt, s1_lin[2][9:0], s1_lin[1][9:0],
                   s1_lin[0][9:0]};
         s2_sat = s1_lin[2][10] | s1_lin[1][10] | s1_lin[0][10];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_val   <= '0;
         out_sat   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_val <= s2_val;
            out_sat <= s2_sat;
         end
      end
   end

   // a saturating item leaving the block beats a same-cycle clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         sat_sticky <= 1'b0;
      else if (out_valid & out_ready & out_sat)
         sat_sticky <= 1'b1;
      else if (sat_clear)
         sat_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_exconv_rgb30a_pack.sv
// Directed bench for exconv_rgb30a_pack.
// Hand-computed vectors, backpressure, async reset and sticky clear.
module tb_exconv_rgb30a_pack;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_val;
   logic [1:0]  in_fmt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_val;
   logic        sat_sticky;
   logic        sat_clear;

   int n_chk = 0;
   int n_err = 0;

   exconv_rgb30a_pack dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_val     (in_val),
      .in_fmt     (in_fmt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_val    (out_val),
      .sat_sticky (sat_sticky),
      .sat_clear  (sat_clear)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [1:0] f, input logic [63:0] v);
      int n;
      @(negedge clock);
      in_fmt   = f;
      in_val   = v;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n == 20) check("push_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic [31:0] v, output int lat);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!out_valid && lat < 20);
      if (!out_valid) check("out_timeout", {31'b0, out_valid}, 32'd1);
      v = out_val;
   endtask

   task automatic vec(input string tag, input logic [1:0] f,
                      input logic [63:0] v, input logic [31:0] exp,
                      input logic sat);
      logic [31:0] got;
      int lat;
      @(negedge clock);
      sat_clear = 1'b1;
      @(negedge clock);
      sat_clear = 1'b0;
      push(f, v);
      wait_out(got, lat);
      check({tag, "_val"}, got, exp);
      check({tag, "_lat"}, lat, 32'd2);
      @(negedge clock);
      check({tag, "_sat"}, {31'b0, sat_sticky}, {31'b0, sat});
   endtask

   initial begin
      logic [31:0] q_val [$];
      int          q_cyc [$];
      int          cnt;
      logic [31:0] got;
      int          lat;

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_val    = '0;
      in_fmt    = '0;
      out_ready = 1'b1;
      sat_clear = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_val", out_val, 32'd0);
      check("rst_sticky", {31'b0, sat_sticky}, 32'd0);
      reset = 1'b1;
      #1 check("rst_in_ready", {31'b0, in_ready}, 32'd1);

      vec("fp8s_all", 2'b10, 64'h3C00_3C00_3C00_3C00, 32'h8E0E1C1C, 1'b0);
      vec("lin_s", 2'b00, 64'h1234_FFC0_0000_0040, 32'h3FF00001, 1'b0);
      vec("lin_u", 2'b01, 64'h0000_8000_0000_0040, 32'h7FF00002, 1'b1);
      vec("g_tie", 2'b10, 64'h0000_0000_3C40_0000, 32'h80001C80, 1'b0);
      vec("g_down", 2'b10, 64'h0000_0000_3C20_0000, 32'h80001C00, 1'b0);
      vec("g_sat", 2'b10, 64'h0000_0000_7BFF_0000, 32'h80003F80, 1'b1);
      vec("g_uflow", 2'b10, 64'h0000_0000_1000_0000, 32'h80000000, 1'b0);
      vec("fp8u_all", 2'b11, 64'h3C00_3C00_3C00_3C00, 32'hDC1C3838, 1'b0);
      vec("u_neg", 2'b11, 64'h0000_0000_0000_BC00, 32'hC0000000, 1'b0);
      vec("g_neg", 2'b10, 64'h0000_0000_BC40_0000, 32'h80005C80, 1'b0);
      vec("r_rnd", 2'b10, 64'h0000_3C80_0000_0000, 32'h800E8000, 1'b0);
      vec("r_rnd_u", 2'b11, 64'h0000_3C40_0000_0000, 32'hC01C8000, 1'b0);
      vec("g_carry", 2'b10, 64'h0000_0000_3FC0_0000, 32'h80002000, 1'b0);
      vec("g_rnd_sat", 2'b10, 64'h0000_0000_5FC0_0000, 32'h80003F80, 1'b1);
      vec("g_inf_neg", 2'b10, 64'h0000_0000_FC00_0000, 32'h80007F80, 1'b1);
      vec("a_inf", 2'b10, 64'h7C00_0000_0000_0000, 32'h9FC00000, 1'b1);

      // backpressure: two items absorbed, third held at the input
      out_ready = 1'b0;
      @(negedge clock);
      in_fmt = 2'b00; in_val = 64'd5 << 6; in_valid = 1'b1;
      #1 check("bp_rdy0", {31'b0, in_ready}, 32'd1);
      @(negedge clock);
      in_val = 64'd6 << 6;
      #1 check("bp_rdy1", {31'b0, in_ready}, 32'd1);
      @(negedge clock);
      in_val = 64'd7 << 6;
      #1 check("bp_rdy2", {31'b0, in_ready}, 32'd0);
      check("bp_held_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clock);
      check("bp_rdy3", {31'b0, in_ready}, 32'd0);
      check("bp_held_val", out_val, 32'd5);
      out_ready = 1'b1;
      #1 check("bp_rdy4", {31'b0, in_ready}, 32'd1);
      for (int c = 0; c < 6; c++) begin
         if (out_valid) begin
            q_val.push_back(out_val);
            q_cyc.push_back(c);
         end
         @(posedge clock);
         if (c == 0) #1 in_valid = 1'b0;
         @(negedge clock);
      end
      check("bp_count", q_val.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < q_val.size()) begin
            check($sformatf("bp_val%0d", i), q_val[i], 32'(5 + i));
            check($sformatf("bp_cyc%0d", i), q_cyc[i], 32'(i));
         end
      end

      // async reset with two items in flight, sticky set beforehand
      vec("pre_rst", 2'b01, 64'h0000_8000_0000_0040, 32'h7FF00002, 1'b1);
      out_ready = 1'b0;
      push(2'b00, 64'd9 << 6);
      push(2'b01, 64'h0000_8000_0000_0000);
      @(negedge clock);
      check("fly_valid", {31'b0, out_valid}, 32'd1);
      #2 reset = 1'b0;
      #1 check("arst_valid", {31'b0, out_valid}, 32'd0);
      check("arst_val", out_val, 32'd0);
      check("arst_sticky", {31'b0, sat_sticky}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      out_ready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (out_valid) cnt++;
      end
      check("arst_no_stale", cnt, 32'd0);

      // clear and set in the same cycle: set wins
      push(2'b01, 64'h0000_8000_0000_0040);
      wait_out(got, lat);
      check("clr_item", got, 32'h7FF00002);
      sat_clear = 1'b1;
      @(negedge clock);
      sat_clear = 1'b0;
      check("clr_set_wins", {31'b0, sat_sticky}, 32'd1);
      sat_clear = 1'b1;
      @(negedge clock);
      sat_clear = 1'b0;
      check("clr_alone", {31'b0, sat_sticky}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
